output_frame_serializer: RTL and testbench
==========================================

OUTPUT_FRAME_SERIALIZER -- requirements
Module: output_frame_serializer

Interface
REQ-001 SHALL have parameter ROWS, default 24: bytes per result column (frame height).
REQ-002 SHALL have parameter COLS, default 32: columns per frame (frame width).
REQ-003 SHALL have port din_clk  input  1  single clock for all logic; the camera-side clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  enable; low freezes column acceptance and read issue.
REQ-006 SHALL have port i_col_data  input  ROWS*8  result column; row 0 at [ROWS*8-1 -: 8].
REQ-007 SHALL have port i_col_vld  input  1  column valid.
REQ-008 SHALL have port o_col_rdy  output  1  column accepted when i_col_vld && o_col_rdy.
REQ-009 SHALL have port o_data_dout  output  8  serialized pixel byte.
REQ-010 SHALL have port o_data_dout_vld  output  1  byte valid.
REQ-011 SHALL have port i_dout_rdy  input  1  downstream ready; transfer = vld && rdy.
REQ-012 SHALL have port o_frame_start  output  1  one-cycle pulse with the first transfer of a frame.
REQ-013 SHALL have port o_frame_done  output  1  one-cycle pulse with the last (ROWS*COLS-th) transfer.

Function
REQ-014 SHALL hold two frame banks (bank 0, 1), each ROWS*COLS bytes; each bank is EMPTY, FILLING, FULL or DRAINING.
REQ-015 Write FSM SHALL have states W_IDLE and W_LOAD; W_IDLE asserts o_col_rdy only when en=1 and bank wr_sel is EMPTY or FILLING.
REQ-016 On acceptance SHALL capture i_col_data into a shift register, enter W_LOAD, deassert o_col_rdy, write one byte per cycle for ROWS cycles, rows 0..ROWS-1.
REQ-017 Write address SHALL be row*COLS + col_cnt (row-major, inverse of the column-parallel input path); col_cnt is 0..COLS-1.
REQ-018 After the last byte of column COLS-1: bank wr_sel becomes FULL, col_cnt wraps to 0, wr_sel toggles, FSM returns to W_IDLE.
REQ-019 If the next bank is not EMPTY, o_col_rdy SHALL stay low until that bank is EMPTY (no overwrite, no column loss).
REQ-020 Read side SHALL start when bank rd_sel is FULL (bank becomes DRAINING); it reads addresses 0..ROWS*COLS-1 in order.
REQ-021 RAM read latency is 1 cycle; the output SHALL be a registered stage with skid such that o_data_dout is stable while o_data_dout_vld=1 and i_dout_rdy=0.
REQ-022 With i_dout_rdy held high, throughput SHALL be 1 byte/cycle; first o_data_dout_vld SHALL rise 2 cycles after the bank becomes FULL.
REQ-023 After the final transfer, bank rd_sel becomes EMPTY and rd_sel toggles in the same cycle; a FULL other bank starts draining with no extra idle cycle beyond REQ-022 latency.
REQ-024 Write into one bank and read from the other SHALL proceed concurrently; a bank becoming EMPTY and a column request in the same cycle SHALL give o_col_rdy=1 the next cycle.
REQ-025 en=0 SHALL deassert o_col_rdy and stop new read issues; an in-progress W_LOAD and any valid output byte SHALL complete/hold; state resumes unchanged when en=1.
REQ-026 Address counters SHALL be ceil(log2(ROWS*COLS)) bits; no arithmetic overflow at ROWS*COLS-1.

Reset
REQ-027 On rst_n low (any time, including mid-frame), all state SHALL clear asynchronously: both banks EMPTY, wr_sel=rd_sel=0, col_cnt=0, FSM W_IDLE.
REQ-028 Reset values SHALL be o_col_rdy=0, o_data_dout=8'h00, o_data_dout_vld=0, o_frame_start=0, o_frame_done=0; RAM contents need not clear.
REQ-029 o_col_rdy SHALL first assert one cycle after rst_n deasserts (with en=1).

Structure
REQ-030 ROWS, COLS, FRAME_BYTES=ROWS*COLS, address width and bank-state encoding SHALL live in the shared pre/post-data package.
REQ-031 Storage SHALL be one sub-module output_frame_ram: simple dual-port, 2*FRAME_BYTES x 8, one write port, one synchronous read port, bank select as address MSB.

Verification
REQ-032 Column bytes = {col, row} pattern, 32 columns back-to-back, i_dout_rdy=1 -> 768 bytes out in row-major order, byte k = {k%32, k/32}, start/done pulses on bytes 0 and 767.
REQ-033 Three frames pushed with i_dout_rdy=0 -> o_col_rdy low after 64 columns until drain; resume with no lost or duplicated column.
REQ-034 Random i_dout_rdy (50%) -> o_data_dout constant while stalled; byte sequence identical to REQ-032.
REQ-035 rst_n pulsed at byte 300 of frame 1 -> all outputs at reset values; next frame starts from address 0 on bank 0.
REQ-036 en=0 during W_LOAD of column 5 -> column 5 completes, o_col_rdy=0 until en=1, output frame still correct.

Source files
------------

// File: rtl/output_frame_serializer_pkg.sv
// Shared definitions for the output frame serializer: frame geometry,
// counter widths and the bank / write-FSM state encodings.
package output_frame_serializer_pkg;

    localparam int ROWS        = 24;
    localparam int COLS        = 32;
    localparam int FRAME_BYTES = ROWS * COLS;

    // Width of a counter that must hold values 0..n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ADDR_W = cnt_width(FRAME_BYTES);

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_LOAD = 1'b1
    } wr_state_e;

    // A bank may take new columns while it is empty or partially written.
    function automatic logic bank_writable(input bank_state_e s);
        return (s == BANK_EMPTY) || (s == BANK_FILLING);
    endfunction

endpackage

// File: rtl/output_frame_serializer_if.sv
// Column input and byte output handshake bundle of the serializer.
interface output_frame_serializer_if #(
    parameter int ROWS = output_frame_serializer_pkg::ROWS
);
    logic [ROWS*8-1:0] i_col_data;
    logic              i_col_vld;
    logic              o_col_rdy;
    logic [7:0]        o_data_dout;
    logic              o_data_dout_vld;
    logic              i_dout_rdy;
    logic              o_frame_start;
    logic              o_frame_done;

    modport master (
        output i_col_data, i_col_vld, i_dout_rdy,
        input  o_col_rdy, o_data_dout, o_data_dout_vld, o_frame_start, o_frame_done
    );

    modport slave (
        input  i_col_data, i_col_vld, i_dout_rdy,
        output o_col_rdy, o_data_dout, o_data_dout_vld, o_frame_start, o_frame_done
    );
endinterface

// File: rtl/output_frame_ram.sv
// Two-bank frame store: simple dual-port, one write port and one
// registered read port. Address MSB selects the bank.
module output_frame_ram #(
    parameter int FRAME_BYTES = output_frame_serializer_pkg::FRAME_BYTES,
    parameter int ADDR_W      = output_frame_serializer_pkg::ADDR_W
) (
    input  logic            clk,
    input  logic            we,
    input  logic [ADDR_W:0] waddr,
    input  logic [7:0]      wdata,
    input  logic            re,
    input  logic [ADDR_W:0] raddr,
    output logic [7:0]      rdata
);
    logic [7:0] mem [2][FRAME_BYTES];

    // Write port: one byte per cycle into the addressed bank.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[ADDR_W]][waddr[ADDR_W-1:0]] <= wdata;
        end
    end

    // Read port: one cycle latency, data held between reads.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr[ADDR_W]][raddr[ADDR_W-1:0]];
        end
    end
endmodule

// File: rtl/output_frame_serializer.sv
// Converts result columns into a row-major byte stream through a
// ping-pong pair of frame banks, with a skid-buffered output stage.
module output_frame_serializer #(
    parameter int ROWS = output_frame_serializer_pkg::ROWS,
    parameter int COLS = output_frame_serializer_pkg::COLS
) (
    input  logic din_clk,
    input  logic rst_n,
    input  logic en,
    output_frame_serializer_if.slave bus
);
    import output_frame_serializer_pkg::*;

    localparam int FRAME_N = ROWS * COLS;
    localparam int AW      = cnt_width(FRAME_N);
    localparam int RW      = cnt_width(ROWS);
    localparam int CW      = cnt_width(COLS);

    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_N - 1);
    localparam logic [AW-1:0] COL_STEP  = AW'(COLS);

    bank_state_e bank_st  [2];
    bank_state_e bank_nxt [2];

    wr_state_e         w_state;
    logic              wr_sel;
    logic [CW-1:0]     col_cnt;
    logic [RW-1:0]     row_cnt;
    logic [AW-1:0]     wr_addr;
    logic [ROWS*8-1:0] col_sr;
    logic              col_rdy;

    logic              rd_sel;
    logic [AW-1:0]     rd_addr;
    logic              rd_all;
    logic              pend, pend_first, pend_last;
    logic [7:0]        ram_rdata;

    logic              out_vld, out_first, out_last;
    logic [7:0]        out_data;
    logic              skid_vld, skid_first, skid_last;
    logic [7:0]        skid_data;

    logic accept, bank_done, xfer, final_xfer, rd_issue;

    assign accept     = (w_state == W_IDLE) && col_rdy && en && bus.i_col_vld;
    assign bank_done  = (w_state == W_LOAD) && (row_cnt == LAST_ROW) && (col_cnt == LAST_COL);
    assign xfer       = out_vld && bus.i_dout_rdy;
    assign final_xfer = xfer && out_last;
    // A read is issued only when the output register and skid together are
    // guaranteed room for it one cycle later.
    assign rd_issue   = en && !skid_vld && (!out_vld || bus.i_dout_rdy) &&
                        ((bank_st[rd_sel] == BANK_FULL) ||
                         ((bank_st[rd_sel] == BANK_DRAINING) && !rd_all));

    assign bus.o_col_rdy       = col_rdy && en;
    assign bus.o_data_dout     = out_data;
    assign bus.o_data_dout_vld = out_vld;
    assign bus.o_frame_start   = xfer && out_first;
    assign bus.o_frame_done    = final_xfer;

    output_frame_ram #(
        .FRAME_BYTES (FRAME_N),
        .ADDR_W      (AW)
    ) u_ram (
        .clk   (din_clk),
        .we    (w_state == W_LOAD),
        .waddr ({wr_sel, wr_addr}),
        .wdata (col_sr[ROWS*8-1 -: 8]),
        .re    (rd_issue),
        .raddr ({rd_sel, rd_addr}),
        .rdata (ram_rdata)
    );

    // Next bank states from write-side and read-side events; the two sides
    // never act on the same bank in one cycle.
    always_comb begin
        bank_nxt = bank_st;
        if (accept && (col_cnt == '0)) bank_nxt[wr_sel] = BANK_FILLING;
        if (bank_done)                 bank_nxt[wr_sel] = BANK_FULL;
        if (rd_issue && (bank_st[rd_sel] == BANK_FULL)) bank_nxt[rd_sel] = BANK_DRAINING;
        if (final_xfer)                bank_nxt[rd_sel] = BANK_EMPTY;
    end

    // Write FSM: capture a column, then store it one row per cycle.
    always_ff @(posedge din_clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            wr_sel  <= 1'b0;
            col_cnt <= '0;
            row_cnt <= '0;
            wr_addr <= '0;
            col_sr  <= '0;
            col_rdy <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (accept) begin
                        col_sr  <= bus.i_col_data;
                        row_cnt <= '0;
                        wr_addr <= AW'(col_cnt);
                        col_rdy <= 1'b0;
                        w_state <= W_LOAD;
                    end else begin
                        col_rdy <= bank_writable(bank_nxt[wr_sel]);
                    end
                end
                W_LOAD: begin
                    col_sr <= {col_sr[ROWS*8-9:0], 8'h00};
                    if (row_cnt == LAST_ROW) begin
                        w_state <= W_IDLE;
                        if (col_cnt == LAST_COL) begin
                            col_cnt <= '0;
                            wr_sel  <= ~wr_sel;
                            col_rdy <= bank_writable(bank_nxt[~wr_sel]);
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                            col_rdy <= bank_writable(bank_nxt[wr_sel]);
                        end
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                        wr_addr <= wr_addr + COL_STEP;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read side: bank ownership, read address issue and output skid stage.
    always_ff @(posedge din_clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
            rd_sel     <= 1'b0;
            rd_addr    <= '0;
            rd_all     <= 1'b0;
            pend       <= 1'b0;
            pend_first <= 1'b0;
            pend_last  <= 1'b0;
            out_vld    <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= 8'h00;
            skid_vld   <= 1'b0;
            skid_first <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= 8'h00;
        end else begin
            bank_st <= bank_nxt;

            pend <= rd_issue;
            if (rd_issue) begin
                pend_first <= (rd_addr == '0);
                pend_last  <= (rd_addr == LAST_ADDR);
                if (rd_addr == LAST_ADDR) begin
                    rd_addr <= '0;
                    rd_all  <= 1'b1;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end

            if (final_xfer) begin
                rd_sel <= ~rd_sel;
                rd_all <= 1'b0;
            end

            // Output register refills from the skid first, then from the RAM;
            // a RAM byte arriving while the output stalls parks in the skid.
            if (!out_vld || xfer) begin
                if (skid_vld) begin
                    out_vld    <= 1'b1;
                    out_data   <= skid_data;
                    out_first  <= skid_first;
                    out_last   <= skid_last;
                    skid_vld   <= pend;
                    if (pend) begin
                        skid_data  <= ram_rdata;
                        skid_first <= pend_first;
                        skid_last  <= pend_last;
                    end
                end else begin
                    out_vld <= pend;
                    if (pend) begin
                        out_data  <= ram_rdata;
                        out_first <= pend_first;
                        out_last  <= pend_last;
                    end
                end
            end else if (pend) begin
                skid_vld   <= 1'b1;
                skid_data  <= ram_rdata;
                skid_first <= pend_first;
                skid_last  <= pend_last;
            end
        end
    end
endmodule

// File: tb/tb_output_frame_serializer.sv
// Directed bench for output_frame_serializer: scoreboarded byte stream,
// frame pulses, stall stability, back-pressure, reset and enable cases.
module tb_output_frame_serializer;

    localparam int ROWS  = 24;
    localparam int COLS  = 32;
    localparam int FRAME = ROWS * COLS;
    localparam int LIMIT = 20000;

    logic din_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic en      = 1'b1;

    output_frame_serializer_if #(.ROWS(ROWS)) bus ();

    output_frame_serializer #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) dut (
        .din_clk (din_clk),
        .rst_n   (rst_n),
        .en      (en),
        .bus     (bus)
    );

    always #5 din_clk = ~din_clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  exp_q[$];
    int          frame_idx = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Hand-chosen pixel pattern for (frame, column, row).
    function automatic logic [7:0] pix(input int f, input int c, input int r);
        return 8'(c * 37 + r * 11 + f * 101);
    endfunction

    function automatic logic [ROWS*8-1:0] make_col(input int f, input int c);
        logic [ROWS*8-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) v[(ROWS-1-r)*8 +: 8] = pix(f, c, r);
        return v;
    endfunction

    // Monitor: compares every transfer against the row-major expectation.
    always @(negedge din_clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_vld", bus.o_data_dout_vld, 1);
                check_eq("stall_data", bus.o_data_dout, prev_data);
            end
            if (bus.o_data_dout_vld && bus.i_dout_rdy) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_byte", bus.o_data_dout_vld, 0);
                end else begin
                    check_eq("byte", bus.o_data_dout, exp_q.pop_front());
                    check_eq("frame_start", bus.o_frame_start, frame_idx == 0);
                    check_eq("frame_done", bus.o_frame_done, frame_idx == FRAME - 1);
                    frame_idx = (frame_idx == FRAME - 1) ? 0 : frame_idx + 1;
                end
            end else if (bus.o_frame_start || bus.o_frame_done) begin
                check_eq("stray_pulse", {bus.o_frame_start, bus.o_frame_done}, 0);
            end
            prev_stall = bus.o_data_dout_vld && !bus.i_dout_rdy;
            prev_data  = bus.o_data_dout;
        end
    end

    task automatic push_col(input int f, input int c);
        int unsigned n;
        n = 0;
        @(posedge din_clk); #1;
        bus.i_col_data = make_col(f, c);
        bus.i_col_vld  = 1'b1;
        do begin
            @(negedge din_clk);
            n++;
        end while (!bus.o_col_rdy && n < LIMIT);
        if (!bus.o_col_rdy) begin
            check_eq("col_rdy_timeout", bus.o_col_rdy, 1);
            bus.i_col_vld = 1'b0;
        end else begin
            @(posedge din_clk); #1;
            bus.i_col_vld = 1'b0;
        end
    endtask

    task automatic expect_frame(input int f);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_q.push_back(pix(f, c, r));
    endtask

    // Pushes all columns of frame f; en drops right after column en_off_col is taken.
    task automatic push_frame(input int f, input int en_off_col);
        expect_frame(f);
        for (int c = 0; c < COLS; c++) begin
            push_col(f, c);
            if (c == en_off_col) begin
                en = 1'b0;
                @(negedge din_clk);
                check_eq("en_off_rdy", bus.o_col_rdy, 0);
                repeat (40) @(negedge din_clk);
                check_eq("en_off_rdy_late", bus.o_col_rdy, 0);
                @(posedge din_clk); #1;
                en = 1'b1;
            end
        end
    endtask

    task automatic wait_drain();
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < LIMIT) begin
            @(negedge din_clk); #1;
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_col_rdy"}, bus.o_col_rdy, 0);
        check_eq({tag, "_dout"}, bus.o_data_dout, 8'h00);
        check_eq({tag, "_vld"}, bus.o_data_dout_vld, 0);
        check_eq({tag, "_start"}, bus.o_frame_start, 0);
        check_eq({tag, "_done"}, bus.o_frame_done, 0);
    endtask

    initial begin
        int unsigned n;
        bus.i_col_data = '0;
        bus.i_col_vld  = 1'b0;
        bus.i_dout_rdy = 1'b1;

        // Reset values and first ready one cycle after release.
        repeat (3) @(negedge din_clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        #1 check_eq("rdy_at_release", bus.o_col_rdy, 0);
        @(negedge din_clk);
        check_eq("rdy_first", bus.o_col_rdy, 1);

        // Frame 0 with continuous downstream ready; first byte 26 edges after
        // the last column is taken (24 writes + FULL->read issue + output reg).
        expect_frame(0);
        for (int c = 0; c < COLS; c++) push_col(0, c);
        repeat (25) @(posedge din_clk);
        @(negedge din_clk);
        check_eq("latency_pre", bus.o_data_dout_vld, 0);
        @(negedge din_clk);
        check_eq("latency_first", bus.o_data_dout_vld, 1);
        wait_drain();

        // Three frames against a stalled sink: the third waits for a free bank.
        @(posedge din_clk); #1;
        bus.i_dout_rdy = 1'b0;
        push_frame(1, -1);
        push_frame(2, -1);
        fork
            push_frame(3, -1);
            begin
                repeat (60) @(negedge din_clk);
                check_eq("bp_col_rdy", bus.o_col_rdy, 0);
                check_eq("bp_vld_held", bus.o_data_dout_vld, 1);
                @(posedge din_clk); #1;
                bus.i_dout_rdy = 1'b1;
            end
        join
        wait_drain();

        // Random downstream ready.
        fork
            push_frame(4, -1);
            begin
                n = 0;
                while ((exp_q.size() != 0 || n == 0) && n < 4 * LIMIT) begin
                    @(posedge din_clk); #1;
                    bus.i_dout_rdy = 1'($urandom_range(0, 1));
                    n++;
                end
                bus.i_dout_rdy = 1'b1;
            end
        join
        wait_drain();

        // Reset in the middle of a frame drain with a partly written next bank.
        @(posedge din_clk); #1;
        bus.i_dout_rdy = 1'b0;
        push_frame(5, -1);
        for (int c = 0; c < 3; c++) push_col(6, c);
        @(posedge din_clk); #1;
        bus.i_dout_rdy = 1'b1;
        n = 0;
        while (frame_idx < 300 && n < LIMIT) begin
            @(negedge din_clk); #1;
            n++;
        end
        check_eq("reach_byte300", frame_idx, 300);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        frame_idx = 0;
        repeat (2) @(negedge din_clk);
        rst_n = 1'b1;
        push_frame(7, -1);
        wait_drain();

        // Enable dropped while column 5 is being stored.
        push_frame(8, 5);
        wait_drain();

        repeat (5) @(negedge din_clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
